periph_arbiter: RTL

Shares one send/ack peripheral, a 4-phase handshake slave with a 4-bit data input, between NREQ CPU-side requesters. Selects requesters in round-robin order and latches the winner's data. Sequences the full handshake: raise send, wait for ack, drop send, wait for ack low. Reports per-requester completion, or an error on handshake timeout.

---
 rtl/periph_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/periph_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one 4-phase send/ack peripheral.
// It latches the winner's data, runs the send/ack handshake, and pulses done or err per requester.
module periph_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DW-1:0]        req_data,
    output logic [NREQ-1:0]           done,
    output logic [NREQ-1:0]           err,
    output logic                      send,
    output logic [DW-1:0]             new_data,
    input  logic                      ack,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_RELEASE = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last;
    logic [DW-1:0]   r_data;
    logic [CW-1:0]   r_cnt;

    logic            w_found;
    logic [GW-1:0]   w_pick;
    logic [DW-1:0]   w_pick_data;

    // Search upward from the requester after the last one served, so a winner drops to lowest priority.
    always_comb begin
        int v_idx;
        w_found     = 1'b0;
        w_pick      = '0;
        w_pick_data = '0;
        v_idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = (int'(r_last) + k) % NREQ;
            if (!w_found && req[v_idx]) begin
                w_found     = 1'b1;
                w_pick      = GW'(v_idx);
                w_pick_data = req_data[v_idx*DW +: DW];
            end
        end
    end

    // Each wait phase gets TIMEOUT cycles; the abort is taken on the last of them.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found && !ack) w_next = S_SEND;
            end
            S_SEND: begin
                if (ack)                    w_next = S_RELEASE;
                else if (r_cnt == CNT_LAST) w_next = S_ERR;
            end
            S_RELEASE: begin
                if (!ack)                   w_next = S_DONE;
                else if (r_cnt == CNT_LAST) w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= GW'(NREQ - 1);
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_SEND) begin
                        r_grant <= w_pick;
                        r_data  <= w_pick_data;
                        r_cnt   <= '0;
                    end
                end
                S_SEND: begin
                    if (w_next == S_RELEASE) r_cnt <= '0;
                    else                     r_cnt <= r_cnt + 1'b1;
                end
                S_RELEASE: r_cnt <= r_cnt + 1'b1;
                S_DONE:    r_last <= r_grant;
                S_ERR:     r_last <= r_grant;
                default:   r_cnt <= '0;
            endcase
        end
    end

    // Every output is decoded from registers only, so reset clears them without a clock edge.
    always_comb begin
        done = '0;
        err  = '0;
        for (int i = 0; i < NREQ; i++) begin
            done[i] = (r_state == S_DONE) && (r_grant == GW'(i));
            err[i]  = (r_state == S_ERR)  && (r_grant == GW'(i));
        end
    end

    assign send     = (r_state == S_SEND);
    assign busy     = (r_state != S_IDLE);
    assign new_data = r_data;
    assign grant_id = r_grant;

endmodule
